// File: rtl/uart_ni_pkg.sv
// rtl/uart_ni_pkg.sv - flit types, widths and FSM states for the UART NI arbiter
package uart_ni_pkg;

  localparam int FLIT_W = 16;

  localparam logic [2:0] FT_REG  = 3'b000;
  localparam logic [2:0] FT_PRIO = 3'b001;
  localparam logic [2:0] FT_TAIL = 3'b110;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    SEND_HEAD,
    SEND_TAIL,
    HOLD
  } state_e;

  function automatic logic [2:0] flit_type(input logic [FLIT_W-1:0] f);
    return f[FLIT_W-1:FLIT_W-3];
  endfunction

endpackage

// File: rtl/uart_ni_arbiter_rr_pick.sv
// rtl/uart_ni_arbiter_rr_pick.sv - combinational round-robin pick, searching upward from ptr+1
module rr_pick #(
  parameter  int N_PORTS = 4,
  localparam int IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic [N_PORTS-1:0] elig_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  // Walk offsets from farthest to nearest so the nearest eligible index wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = N_PORTS; k >= 1; k--) begin
      if (elig_i[(int'(ptr_i) + k) % N_PORTS]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'((int'(ptr_i) + k) % N_PORTS);
      end
    end
  end

endmodule

// File: rtl/uart_ni_arbiter.sv
// rtl/uart_ni_arbiter.sv - buffers two-flit packets from N sources and forwards them to one UART NI
module uart_ni_arbiter
  import uart_ni_pkg::*;
#(
  parameter int N_PORTS      = 4,
  parameter int HOLD_CYCLES  = 4096,
  parameter int TAIL_TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS-1:0]        req_i,
  input  logic [FLIT_W*N_PORTS-1:0] flit_i,
  output logic [N_PORTS-1:0]        ack_o,
  output logic [N_PORTS-1:0]        grant_o,
  output logic [FLIT_W-1:0]         ni_data,
  output logic                      ni_req,
  input  logic                      ni_busy,
  output logic                      err_o
);

  localparam int IDX_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int TMO_W  = (TAIL_TIMEOUT > 1) ? $clog2(TAIL_TIMEOUT) : 1;

  state_e               state_q, state_d;
  logic [N_PORTS-1:0]   grant_q, grant_d;
  logic [FLIT_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [FLIT_W-1:0]    ni_data_q, ni_data_d;
  logic                 ni_req_q, ni_req_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [IDX_W-1:0]     prio_ptr_q, prio_ptr_d, reg_ptr_q, reg_ptr_d;
  logic [IDX_W-1:0]     win_q, win_d;
  logic                 win_prio_q, win_prio_d;

  logic [FLIT_W-1:0]    flits [N_PORTS];
  logic [N_PORTS-1:0]   prio_elig, reg_elig, bad;
  logic                 p_found, r_found;
  logic [IDX_W-1:0]     p_idx, r_idx, bad_idx;
  logic [N_PORTS-1:0]   ack_c;
  logic                 err_c;

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      flits[i]     = flit_i[FLIT_W*i +: FLIT_W];
      prio_elig[i] = req_i[i] && (flit_type(flits[i]) == FT_PRIO);
      reg_elig[i]  = req_i[i] && (flit_type(flits[i]) == FT_REG);
      bad[i]       = req_i[i] && !prio_elig[i] && !reg_elig[i];
    end
    bad_idx = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (bad[i]) bad_idx = IDX_W'(i);
    end
  end

  rr_pick #(.N_PORTS(N_PORTS)) u_pick_prio (
    .elig_i (prio_elig), .ptr_i (prio_ptr_q), .found_o (p_found), .idx_o (p_idx)
  );

  rr_pick #(.N_PORTS(N_PORTS)) u_pick_reg (
    .elig_i (reg_elig), .ptr_i (reg_ptr_q), .found_o (r_found), .idx_o (r_idx)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    head_d     = head_q;
    tail_d     = tail_q;
    tmo_d      = tmo_q;
    hold_d     = hold_q;
    prio_ptr_d = prio_ptr_q;
    reg_ptr_d  = reg_ptr_q;
    win_d      = win_q;
    win_prio_d = win_prio_q;
    ni_req_d   = 1'b0;
    ni_data_d  = '0;
    ack_c      = '0;
    err_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (p_found || r_found) begin
          win_d        = p_found ? p_idx : r_idx;
          win_prio_d   = p_found;
          head_d       = flits[win_d];
          ack_c[win_d] = 1'b1;
          grant_d      = N_PORTS'(1) << win_d;
          tmo_d        = '0;
          state_d      = COLLECT;
        end else if (|bad) begin
          ack_c[bad_idx] = 1'b1;
          err_c          = 1'b1;
        end
      end
      COLLECT: begin
        if (req_i[win_q]) begin
          ack_c[win_q] = 1'b1;
          if (flit_type(flits[win_q]) == FT_TAIL) begin
            tail_d  = flits[win_q];
            state_d = SEND_HEAD;
          end else begin
            err_c   = 1'b1;
            grant_d = '0;
            state_d = IDLE;
          end
        end else if (tmo_q == TMO_W'(TAIL_TIMEOUT - 1)) begin
          err_c   = 1'b1;
          grant_d = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      SEND_HEAD: begin
        if (!ni_busy) begin
          ni_req_d  = 1'b1;
          ni_data_d = head_q;
          state_d   = SEND_TAIL;
        end
      end
      SEND_TAIL: begin
        // No busy check here: the NI requires the tail on the very next cycle.
        ni_req_d  = 1'b1;
        ni_data_d = tail_q;
        if (win_prio_q) prio_ptr_d = win_q;
        else            reg_ptr_d  = win_q;
        hold_d  = '0;
        state_d = HOLD;
      end
      HOLD: begin
        if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          if (!ni_busy) begin
            grant_d = '0;
            state_d = IDLE;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      tmo_q      <= '0;
      hold_q     <= '0;
      prio_ptr_q <= IDX_W'(N_PORTS - 1);
      reg_ptr_q  <= IDX_W'(N_PORTS - 1);
      win_q      <= '0;
      win_prio_q <= 1'b0;
      ni_req_q   <= 1'b0;
      ni_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      tmo_q      <= tmo_d;
      hold_q     <= hold_d;
      prio_ptr_q <= prio_ptr_d;
      reg_ptr_q  <= reg_ptr_d;
      win_q      <= win_d;
      win_prio_q <= win_prio_d;
      ni_req_q   <= ni_req_d;
      ni_data_q  <= ni_data_d;
    end
  end

  // Combinational pulses are masked while reset is held so nothing is consumed.
  assign ack_o   = rst ? ack_c : '0;
  assign err_o   = rst & err_c;
  assign grant_o = grant_q;
  assign ni_req  = ni_req_q;
  assign ni_data = ni_data_q;

endmodule

// File: tb/tb_uart_ni_arbiter.sv
// tb/tb_uart_ni_arbiter.sv - scoreboard bench for uart_ni_arbiter
module tb_uart_ni_arbiter;

  localparam int N    = 4;
  localparam int HOLD = 16;
  localparam int TMO  = 8;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_i;
  logic [16*N-1:0] flit_i;
  logic [N-1:0]    ack_o;
  logic [N-1:0]    grant_o;
  logic [15:0]     ni_data;
  logic            ni_req;
  logic            ni_busy;
  logic            err_o;

  uart_ni_arbiter #(.N_PORTS(N), .HOLD_CYCLES(HOLD), .TAIL_TIMEOUT(TMO)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_i),
    .flit_i  (flit_i),
    .ack_o   (ack_o),
    .grant_o (grant_o),
    .ni_data (ni_data),
    .ni_req  (ni_req),
    .ni_busy (ni_busy),
    .err_o   (err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [15:0]  flit_a [N];
  logic [15:0]  srcq [N][$];
  logic [15:0]  exp_ni [$];
  logic [N-1:0] exp_grant [$];
  int           ack_cnt [N];
  int           err_cnt;
  int           last_glen;
  int           n_checks;
  int           n_pass;

  always_comb begin
    for (int i = 0; i < N; i++) flit_i[i*16 +: 16] = flit_a[i];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  function automatic bit srcq_empty();
    for (int i = 0; i < N; i++) if (srcq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Source model: each port presents the front of its queue until it is acked.
  initial begin : driver
    logic [N-1:0] ackd;
    req_i = '0;
    for (int i = 0; i < N; i++) flit_a[i] = '0;
    forever begin
      @(negedge clk);
      ackd = ack_o;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (ackd[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        req_i[i]  = (srcq[i].size() > 0);
        flit_a[i] = (srcq[i].size() > 0) ? srcq[i][0] : 16'h0000;
      end
    end
  end

  initial begin : monitor
    logic         prev_req;
    logic [N-1:0] prev_grant;
    logic [15:0]  e;
    int           glen;
    prev_req   = 1'b0;
    prev_grant = '0;
    glen       = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (ack_o[i]) ack_cnt[i]++;
      if (err_o) err_cnt++;
      if (ni_req) begin
        if (exp_ni.size() == 0) begin
          check("ni_unexpected", ni_req, 0);
        end else begin
          e = exp_ni.pop_front();
          check("ni_data", ni_data, e);
          if (e[15:13] == 3'b110) check("ni_consecutive", prev_req, 1);
        end
      end
      prev_req = ni_req;
      if (grant_o != 0 && prev_grant == 0) begin
        if (exp_grant.size() == 0) check("grant_unexpected", grant_o, 0);
        else check("grant", grant_o, exp_grant.pop_front());
        glen = 0;
      end
      if (grant_o != 0) glen++;
      else if (prev_grant != 0) last_glen = glen;
      prev_grant = grant_o;
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (n < budget && !(grant_o == 0 && srcq_empty() &&
                           exp_ni.size() == 0 && exp_grant.size() == 0)) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) check("idle_timeout", n, budget - 1);
    repeat (2) @(posedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic push_pkt(input int p, input logic [15:0] h, input logic [15:0] t);
    srcq[p].push_back(h);
    srcq[p].push_back(t);
    exp_ni.push_back(h);
    exp_ni.push_back(t);
    exp_grant.push_back(N'(1) << p);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int e0, a0, a1, a2;
    n_checks = 0;
    n_pass   = 0;
    err_cnt  = 0;
    last_glen = 0;
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    ni_busy = 1'b0;
    rst     = 1'b0;
    #12;
    check("rst_grant", grant_o, 0);
    check("rst_ni_req", ni_req, 0);
    check("rst_ni_data", ni_data, 0);
    check("rst_err", err_o, 0);
    check("rst_ack", ack_o, 0);
    @(negedge clk);
    rst = 1'b1;

    // Single packet on port 1; grant spans COLLECT, two send cycles and HOLD.
    push_pkt(1, 16'h0000, 16'hC0AB);
    wait_idle(500);
    check("p1_acks", ack_cnt[1], 2);
    check("p1_grant_len", last_glen, HOLD + 3);

    // Priority on port 2 beats a same-cycle regular head on port 0.
    push_pkt(2, 16'h2000, 16'hC002);
    push_pkt(0, 16'h0000, 16'hC000);
    srcq[2].delete();
    srcq[0].delete();
    exp_grant.delete();
    exp_ni.delete();
    srcq[0].push_back(16'h0000);
    srcq[0].push_back(16'hC000);
    srcq[2].push_back(16'h2000);
    srcq[2].push_back(16'hC002);
    exp_grant.push_back(4'b0100);
    exp_grant.push_back(4'b0001);
    exp_ni.push_back(16'h2000);
    exp_ni.push_back(16'hC002);
    exp_ni.push_back(16'h0000);
    exp_ni.push_back(16'hC000);
    wait_idle(1000);

    // Round-robin among regular sources 0, 1, 3 from a fresh pointer state.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      srcq[0].push_back(16'h0010 + 16'(r)); srcq[0].push_back(16'hC010 + 16'(r));
      srcq[1].push_back(16'h0020 + 16'(r)); srcq[1].push_back(16'hC020 + 16'(r));
      srcq[3].push_back(16'h0030 + 16'(r)); srcq[3].push_back(16'hC030 + 16'(r));
    end
    for (int r = 0; r < 2; r++) begin
      exp_grant.push_back(4'b0001); exp_ni.push_back(16'h0010 + 16'(r)); exp_ni.push_back(16'hC010 + 16'(r));
      exp_grant.push_back(4'b0010); exp_ni.push_back(16'h0020 + 16'(r)); exp_ni.push_back(16'hC020 + 16'(r));
      exp_grant.push_back(4'b1000); exp_ni.push_back(16'h0030 + 16'(r)); exp_ni.push_back(16'hC030 + 16'(r));
    end
    wait_idle(2000);

    // Head with no tail: a single timeout error, no NI traffic.
    e0 = err_cnt;
    a0 = ack_cnt[0];
    srcq[0].push_back(16'h0044);
    exp_grant.push_back(4'b0001);
    wait_idle(200);
    check("tmo_err", err_cnt - e0, 1);
    check("tmo_ack", ack_cnt[0] - a0, 1);

    // Head followed by a non-tail flit: both acked, one error.
    e0 = err_cnt;
    a2 = ack_cnt[2];
    srcq[2].push_back(16'h0005);
    srcq[2].push_back(16'h0001);
    exp_grant.push_back(4'b0100);
    wait_idle(200);
    check("badtail_err", err_cnt - e0, 1);
    check("badtail_ack", ack_cnt[2] - a2, 2);

    // A stray tail in IDLE is discarded with an error and no grant.
    e0 = err_cnt;
    a1 = ack_cnt[1];
    srcq[1].push_back(16'hC123);
    wait_idle(100);
    check("stray_err", err_cnt - e0, 1);
    check("stray_ack", ack_cnt[1] - a1, 1);

    // HOLD saturates while the NI is busy; reset clears everything at once.
    push_pkt(3, 16'h0033, 16'hC033);
    for (int n = 0; n < 200 && exp_ni.size() != 0; n++) @(posedge clk);
    check("hold_sent", exp_ni.size(), 0);
    #1;
    ni_busy = 1'b1;
    repeat (HOLD + 4) @(negedge clk);
    check("hold_saturated", grant_o, 4'b1000);
    #2;
    rst = 1'b0;
    #1;
    check("arst_grant", grant_o, 0);
    check("arst_ni_req", ni_req, 0);
    check("arst_ni_data", ni_data, 0);
    check("arst_ack", ack_o, 0);
    @(negedge clk);
    rst     = 1'b1;
    ni_busy = 1'b0;
    a0 = ack_cnt[3];
    push_pkt(3, 16'h0133, 16'hC133);
    wait_idle(500);
    check("post_rst_acks", ack_cnt[3] - a0, 2);
    check("ni_leftover", exp_ni.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_ni_arbiter.md
Name: uart_ni_arbiter

Overview:
Shares one router_UART_NI between N router-side packet sources. Each source sends two-flit packets: a head flit (type 000 regular or 001 priority) followed by a tail flit (type 110). The block buffers each complete packet, then presents it to the NI as back-to-back head and tail flits on consecutive cycles. It then holds off the NI until its serial transfer is finished. Priority packets go before regular ones; sources within a class are served round-robin.

Parameters:
N_PORTS, 4, number of requesting sources (2..8)
HOLD_CYCLES, 4096, clk cycles to hold after a send; must cover 640 NI uart ticks plus margin
TAIL_TIMEOUT, 64, max clk cycles to wait for the tail flit after head capture

Ports:
clk  in  1  single system clock; all logic on posedge
rst  in  1  asynchronous, active-low reset
req_i  in  N_PORTS  per-source flit valid
flit_i  in  16*N_PORTS  per-source flit; source i at [16i+15:16i]
ack_o  out  N_PORTS  one-cycle combinational pulse: flit of source i consumed this cycle
grant_o  out  N_PORTS  one-hot registered owner, 0 in IDLE
ni_data  out  16  flit to the NI data input
ni_req  out  1  flit valid to the NI req input
ni_busy  in  1  NI busy; currently tied 0 in the NI, honoured anyway
err_o  out  1  one-cycle pulse on a protocol error or timeout

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; grant_o, ni_data, ni_req, err_o, ack_o, buffers and counters = 0.
  - Both round-robin pointers = N_PORTS-1, so port 0 is searched first.
- Flit type is flit[15:13]. Eligible head: req_i[i]=1 and type 000 or 001.
- State IDLE:
  - If any eligible priority head exists, pick one using prio_ptr. Otherwise pick an eligible regular head using reg_ptr.
  - Round-robin pick = first eligible index searching from ptr+1 upward, wrapping at N_PORTS.
  - On a pick: head_buf<=flit, ack_o[winner]=1, grant_o<=onehot(winner), tmo<=0, go to COLLECT.
  - If nothing is eligible but some req_i[i]=1 carries an invalid type: the lowest such i is acked and discarded, err_o=1, stay in IDLE.
- State COLLECT:
  - Granted source has req=1 with type 110: tail_buf<=flit, ack, go to SEND_HEAD.
  - Granted source has req=1 with any other type: ack and discard, err_o=1, go to IDLE (head dropped).
  - No req: tmo++. When tmo reaches TAIL_TIMEOUT-1: err_o=1, go to IDLE.
  - Other sources are never acked in this state.
- State SEND_HEAD:
  - Enter only if ni_busy=0; otherwise wait here with ni_req=0.
  - When sending: ni_req=1, ni_data=head_buf, go to SEND_TAIL.
- State SEND_TAIL:
  - ni_req=1, ni_data=tail_buf.
  - Update the pointer of the winner's class to the winner index.
  - Clear hold counter, go to HOLD.
  - Head and tail reach the NI on exactly consecutive cycles; the NI needs this.
- State HOLD:
  - ni_req=0, ni_data=0, hold counter++.
  - Exit to IDLE when counter==HOLD_CYCLES-1 and ni_busy=0. If ni_busy=1, stay (counter saturates).
  - grant_o clears on exit.
- ni_req and ni_data are registered: state outputs appear the cycle after state entry, with the same relative timing. Throughput is at most one packet per HOLD_CYCLES+4 cycles.
- Flits pass unchanged. The sequence address in flit[7:0] is the source's responsibility; the NI silently drops mismatched heads.
- Simultaneous priority and regular heads: priority wins; the regular source keeps its flit until a later IDLE grant.
- Reset mid-operation: buffered packet lost; ni_req drops immediately (async); no ack is issued.
- Counters are sized with $clog2 of their parameter; no wrap-around.

Decomposition:
- Package uart_ni_pkg:
  - flit type localparams FT_REG=3'b000, FT_PRIO=3'b001, FT_TAIL=3'b110;
  - FLIT_W=16;
  - state encoding IDLE/COLLECT/SEND_HEAD/SEND_TAIL/HOLD.
- Sub-module rr_pick (N_PORTS): inputs eligible vector and ptr; outputs found flag and winner index. Combinational; instantiated twice, once per class.

Test Plan:
- Port 1 head 16'h0000 then tail 16'hC0AB: ni_req high two consecutive cycles with 0000 then C0AB; ack_o[1] pulses twice; HOLD lasts HOLD_CYCLES.
- Same cycle: port 0 regular head 16'h0000, port 2 priority head 16'h2000: port 2 served first; port 0 served after HOLD.
- Ports 0, 1, 3 hold regular heads continuously, each followed by a tail: grant order is 0, 1, 3, 0, 1, 3.
- Port 0 head, then no tail for TAIL_TIMEOUT cycles: err_o pulses once, state returns to IDLE, ni_req never asserts.
- Port 2 head followed by 16'h0001 (type 000 instead of 110): second flit acked, err_o=1, no NI traffic.
- rst asserted in HOLD while ni_busy=1: all outputs 0 immediately. After release, a new packet on port 3 is served from IDLE.
